// File: rtl/branch_predictor.sv
// Bimodal branch predictor with a direct-mapped BTB, trained from the execute stage.
// Optional build macro: BRANCH_PRED_STATS_EN adds branch/mispredict statistics counters.
module branch_predictor #(
  parameter int ENTRIES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic        bp_ready,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  localparam int IDX = $clog2(ENTRIES);
  localparam int TAG = 30 - IDX;

  typedef enum logic {INIT, RUN} state_t;

  state_t           r_state;
  logic [IDX-1:0]   r_sweepIdx;
  logic             r_bpReady;
  logic             r_mispredict;
  logic [31:0]      r_redirectPc;

  logic             r_valid  [ENTRIES];
  logic [TAG-1:0]   r_tag    [ENTRIES];
  logic [31:0]      r_target [ENTRIES];
  logic [1:0]       r_ctr    [ENTRIES];

  logic [IDX-1:0]   w_ifIdx;
  logic [TAG-1:0]   w_ifTag;
  logic             w_hit;
  logic [IDX-1:0]   w_exIdx;
  logic [TAG-1:0]   w_exTag;
  logic [1:0]       w_exCtr;
  logic [1:0]       w_ctrNext;
  logic             w_train;
  logic             w_mispredict;
  logic [31:0]      w_redirect;

  assign w_ifIdx = if_pc[IDX+1:2];
  assign w_ifTag = if_pc[31:IDX+2];
  assign w_exIdx = ex_pc[IDX+1:2];
  assign w_exTag = ex_pc[31:IDX+2];

  // Lookup reads stored state only, so a same-cycle update is not bypassed.
  assign w_hit       = r_valid[w_ifIdx] && (r_tag[w_ifIdx] == w_ifTag);
  assign pred_taken  = (r_state == RUN) && w_hit && r_ctr[w_ifIdx][1];
  assign pred_target = pred_taken ? r_target[w_ifIdx] : if_pc + 32'd4;

  assign w_exCtr   = r_ctr[w_exIdx];
  assign w_ctrNext = ex_taken ? ((w_exCtr == 2'b11) ? 2'b11 : w_exCtr + 2'b01)
                              : ((w_exCtr == 2'b00) ? 2'b00 : w_exCtr - 2'b01);

  assign w_train      = (r_state == RUN) && ex_valid && ex_is_branch;
  assign w_mispredict = w_train &&
                        ((ex_taken != ex_pred_taken) ||
                         (ex_taken && ex_pred_taken && (ex_target != ex_pred_target)));
  assign w_redirect   = ex_taken ? ex_target : ex_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= INIT;
      r_sweepIdx   <= '0;
      r_bpReady    <= 1'b0;
      r_mispredict <= 1'b0;
      r_redirectPc <= '0;
    end else begin
      case (r_state)
        INIT: begin
          r_valid[r_sweepIdx] <= 1'b0;
          r_ctr[r_sweepIdx]   <= 2'b01;
          r_sweepIdx          <= r_sweepIdx + 1'b1;
          r_mispredict        <= 1'b0;
          if (r_sweepIdx == IDX'(ENTRIES - 1)) begin
            r_state   <= RUN;
            r_bpReady <= 1'b1;
          end
        end
        RUN: begin
          r_mispredict <= w_mispredict;
          if (w_train) begin
            r_ctr[w_exIdx] <= w_ctrNext;
            r_redirectPc   <= w_redirect;
            if (ex_taken) begin
              r_valid[w_exIdx]  <= 1'b1;
              r_tag[w_exIdx]    <= w_exTag;
              r_target[w_exIdx] <= ex_target;
            end
          end
        end
        default: r_state <= INIT;
      endcase
    end
  end

  assign bp_ready    = r_bpReady;
  assign mispredict  = r_mispredict;
  assign redirect_pc = r_redirectPc;

`ifdef BRANCH_PRED_STATS_EN
  logic [31:0] r_statBranches;
  logic [31:0] r_statMispredicts;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_statBranches    <= '0;
      r_statMispredicts <= '0;
    end else begin
      if (w_train)      r_statBranches    <= r_statBranches + 32'd1;
      if (w_mispredict) r_statMispredicts <= r_statMispredicts + 32'd1;
    end
  end

  assign stat_branches    = r_statBranches;
  assign stat_mispredicts = r_statMispredicts;
`else
  assign stat_branches    = 32'd0;
  assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: table of lookup/training vectors with a
// scoreboard for the registered mispredict/redirect, plus reset and sweep sequences.
module tb_branch_predictor;

  localparam int ENTRIES = 64;

  logic        clk;
  logic        rst_n;
  logic [31:0] ifPc;
  logic        predTaken;
  logic [31:0] predTarget;
  logic        bpReady;
  logic        exValid;
  logic        exIsBranch;
  logic [31:0] exPc;
  logic        exTaken;
  logic [31:0] exTarget;
  logic        exPredTaken;
  logic [31:0] exPredTarget;
  logic        mispredictOut;
  logic [31:0] redirectPc;
  logic [31:0] statBranches;
  logic [31:0] statMispredicts;

  int checks   = 0;
  int failures = 0;
  int expBranches = 0;
  int expMispredicts = 0;

  typedef struct {
    logic [31:0] ifPc;
    logic        exValid;
    logic        exBranch;
    logic [31:0] exPc;
    logic        exTaken;
    logic [31:0] exTarget;
    logic        exPredTaken;
    logic [31:0] exPredTarget;
    logic        expTaken;
    logic [31:0] expTarget;
    logic        expMis;
    logic [31:0] expRedirect;
  } vec_t;

  typedef struct {
    logic        mis;
    logic [31:0] redirect;
    int          row;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbQ[$];

  branch_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_pc            (ifPc),
    .pred_taken       (predTaken),
    .pred_target      (predTarget),
    .bp_ready         (bpReady),
    .ex_valid         (exValid),
    .ex_is_branch     (exIsBranch),
    .ex_pc            (exPc),
    .ex_taken         (exTaken),
    .ex_target        (exTarget),
    .ex_pred_taken    (exPredTaken),
    .ex_pred_target   (exPredTarget),
    .mispredict       (mispredictOut),
    .redirect_pc      (redirectPc),
    .stat_branches    (statBranches),
    .stat_mispredicts (statMispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  task automatic addVec(input logic [31:0] ip, input logic v, input logic b, input logic [31:0] ep,
                        input logic t, input logic [31:0] tg, input logic pt, input logic [31:0] ptg,
                        input logic et, input logic [31:0] etg, input logic em, input logic [31:0] er);
    vec_t x;
    x.ifPc = ip; x.exValid = v; x.exBranch = b; x.exPc = ep; x.exTaken = t; x.exTarget = tg;
    x.exPredTaken = pt; x.exPredTarget = ptg; x.expTaken = et; x.expTarget = etg;
    x.expMis = em; x.expRedirect = er;
    vecs.push_back(x);
    if (v && b) expBranches++;
    if (em) expMispredicts++;
  endtask

  task automatic driveEx(input logic v, input logic b, input logic [31:0] ep, input logic t,
                         input logic [31:0] tg, input logic pt, input logic [31:0] ptg);
    exValid = v; exIsBranch = b; exPc = ep; exTaken = t; exTarget = tg;
    exPredTaken = pt; exPredTarget = ptg;
  endtask

  // Drive one row at the falling edge, check the combinational lookup, queue the registered result.
  task automatic applyStimulus(input int row);
    sb_t s;
    @(negedge clk);
    ifPc = vecs[row].ifPc;
    driveEx(vecs[row].exValid, vecs[row].exBranch, vecs[row].exPc, vecs[row].exTaken,
            vecs[row].exTarget, vecs[row].exPredTaken, vecs[row].exPredTarget);
    s.mis = vecs[row].expMis; s.redirect = vecs[row].expRedirect; s.row = row;
    sbQ.push_back(s);
    #1;
    checkOutput($sformatf("row%0d_pred_taken", row), {31'd0, predTaken}, {31'd0, vecs[row].expTaken});
    checkOutput($sformatf("row%0d_pred_target", row), predTarget, vecs[row].expTarget);
  endtask

  task automatic retireRow();
    sb_t s;
    @(posedge clk);
    #1;
    if (sbQ.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_empty actual=0 expected=1");
    end else begin
      s = sbQ.pop_front();
      checkOutput($sformatf("row%0d_mispredict", s.row), {31'd0, mispredictOut}, {31'd0, s.mis});
      if (s.mis) checkOutput($sformatf("row%0d_redirect_pc", s.row), redirectPc, s.redirect);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ifPc  = 32'h0;
    driveEx(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Row table: lookup expectation is pre-update state; mispredict appears after the edge.
    addVec(32'h100, 1,1, 32'h100, 1, 32'h200, 0, 32'h104,  0, 32'h104, 1, 32'h200);
    addVec(32'h100, 0,0, 32'h0,   0, 32'h0,   0, 32'h0,    1, 32'h200, 0, 32'h0);
    addVec(32'h100, 1,1, 32'h100, 1, 32'h200, 1, 32'h200,  1, 32'h200, 0, 32'h0);
    addVec(32'h100, 1,1, 32'h100, 0, 32'h200, 1, 32'h200,  1, 32'h200, 1, 32'h104);
    addVec(32'h100, 1,1, 32'h100, 0, 32'h200, 1, 32'h200,  1, 32'h200, 1, 32'h104);
    addVec(32'h100, 1,1, 32'h100, 0, 32'h200, 0, 32'h0,    0, 32'h104, 0, 32'h0);
    addVec(32'h100, 1,1, 32'h100, 0, 32'h200, 0, 32'h0,    0, 32'h104, 0, 32'h0);
    addVec(32'h100, 1,1, 32'h100, 1, 32'h200, 0, 32'h104,  0, 32'h104, 1, 32'h200);
    addVec(32'h100, 0,0, 32'h0,   0, 32'h0,   0, 32'h0,    0, 32'h104, 0, 32'h0);
    addVec(32'h100, 1,1, 32'h100, 1, 32'h200, 0, 32'h104,  0, 32'h104, 1, 32'h200);
    addVec(32'h100 + 4*ENTRIES, 1,0, 32'h100, 0, 32'h200, 1, 32'h200, 0, 32'h104 + 4*ENTRIES, 0, 32'h0);
    addVec(32'h100, 0,0, 32'h0,   0, 32'h0,   0, 32'h0,    1, 32'h200, 0, 32'h0);
    addVec(32'h300, 1,1, 32'h300, 1, 32'h400, 1, 32'h300,  0, 32'h304, 1, 32'h400);
    addVec(32'h300, 0,1, 32'h300, 0, 32'h0,   1, 32'h400,  1, 32'h400, 0, 32'h0);
    addVec(32'h300, 1,1, 32'hFFFF_FFFC, 0, 32'h10, 1, 32'h10, 1, 32'h400, 1, 32'h0);
    addVec(32'hFFFF_FFFC, 1,1, 32'h300, 1, 32'h400, 1, 32'h400, 0, 32'h0, 0, 32'h0);
    addVec(32'h500, 0,0, 32'h0,   0, 32'h0,   0, 32'h0,    0, 32'h504, 0, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_bp_ready", {31'd0, bpReady}, 32'd0);
    checkOutput("reset_mispredict", {31'd0, mispredictOut}, 32'd0);
    checkOutput("reset_redirect_pc", redirectPc, 32'd0);
    checkOutput("reset_stat_branches", statBranches, 32'd0);

    // Sweep: training offered throughout must be ignored, lookups fall through to pc+4.
    for (int k = 1; k <= ENTRIES; k++) begin
      @(negedge clk);
      rst_n = 1'b1;
      ifPc  = (k == 5) ? 32'hFFFF_FFFC : 32'h1000 + 32'(k) * 32'd4;
      driveEx(1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
      #1;
      checkOutput($sformatf("init%0d_pred_taken", k), {31'd0, predTaken}, 32'd0);
      checkOutput($sformatf("init%0d_pred_target", k), predTarget, ifPc + 32'd4);
      @(posedge clk);
      #1;
      checkOutput($sformatf("init%0d_bp_ready", k), {31'd0, bpReady}, (k == ENTRIES) ? 32'd1 : 32'd0);
      checkOutput($sformatf("init%0d_mispredict", k), {31'd0, mispredictOut}, 32'd0);
    end

    for (int r = 0; r < vecs.size(); r++) begin
      applyStimulus(r);
      retireRow();
    end

`ifdef BRANCH_PRED_STATS_EN
    checkOutput("stat_branches", statBranches, 32'(expBranches));
    checkOutput("stat_mispredicts", statMispredicts, 32'(expMispredicts));
`else
    checkOutput("stat_branches_off", statBranches, 32'd0);
    checkOutput("stat_mispredicts_off", statMispredicts, 32'd0);
`endif

    // Reset mid-run while a mispredicting branch is offered.
    @(negedge clk);
    rst_n = 1'b0;
    ifPc  = 32'h100;
    driveEx(1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    @(posedge clk);
    #1;
    checkOutput("midrun_reset_mispredict", {31'd0, mispredictOut}, 32'd0);
    checkOutput("midrun_reset_bp_ready", {31'd0, bpReady}, 32'd0);
    checkOutput("midrun_reset_redirect_pc", redirectPc, 32'd0);
    checkOutput("midrun_reset_stat_branches", statBranches, 32'd0);
    checkOutput("midrun_reset_stat_mispredicts", statMispredicts, 32'd0);

    // Partial sweep, then reset mid-sweep; the full sweep must restart from index 0.
    @(negedge clk);
    rst_n = 1'b1;
    driveEx(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midsweep_reset_bp_ready", {31'd0, bpReady}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= ENTRIES; k++) begin
      @(posedge clk);
      #1;
      if (k == ENTRIES - 1) checkOutput("resweep_bp_ready_early", {31'd0, bpReady}, 32'd0);
      if (k == ENTRIES)     checkOutput("resweep_bp_ready", {31'd0, bpReady}, 32'd1);
    end

    @(negedge clk);
    ifPc = 32'h100;
    #1;
    checkOutput("post_reset_pred_taken", {31'd0, predTaken}, 32'd0);
    checkOutput("post_reset_pred_target", predTarget, 32'h104);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Bimodal branch predictor with a direct-mapped branch target buffer (BTB) for the core's fetch stage. It closes the loop with the execute-stage branch comparator. It predicts taken/target for the fetch PC and is trained by the resolved `branch_tk` outcome. It also raises a registered mispredict/redirect to flush fetch and decode.

## Interface
- `ENTRIES`, 64: BHT/BTB entry count; power of 2, ≥4; `IDX = log2(ENTRIES)`, `TAG = 30-IDX`.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `if_pc` in 32: current fetch PC (word aligned).
- `pred_taken` out 1: predicted taken for `if_pc`.
- `pred_target` out 32: predicted next PC for `if_pc`.
- `bp_ready` out 1: table initialised; predictions and training active.
- `ex_valid` in 1: execute-stage instruction valid.
- `ex_is_branch` in 1: conditional branch (`BRA_con != 0`).
- `ex_pc` in 32: PC of the execute-stage instruction.
- `ex_taken` in 1: resolved outcome (comparator `branch_tk`).
- `ex_target` in 32: computed branch target.
- `ex_pred_taken` in 1: prediction carried down the pipe with this instruction.
- `ex_pred_target` in 32: predicted target carried down the pipe with this instruction.
- `mispredict` out 1: registered flush request, one-cycle pulse.
- `redirect_pc` out 32: registered correct next PC; qualified by `mispredict`.
- `stat_branches` out 32: resolved-branch count (macro only).
- `stat_mispredicts` out 32: mispredict count (macro only).

## Operation
- Entry fields: `valid`, `tag = pc[31:IDX+2]`, `target[31:0]`, `ctr[1:0]` (2-bit saturating counter). Index = `pc[IDX+1:2]`.
- FSM states `INIT` and `RUN`.
- `INIT` is entered on any cycle with `rst_n=0`. It sweeps index 0..ENTRIES-1, one entry per cycle, writing `valid=0` and `ctr=2'b01` (weakly not-taken).
- After the sweep, the FSM moves to `RUN`.
- In `INIT`:
  - `bp_ready=0`, `pred_taken=0`, `pred_target=if_pc+4`.
  - Training inputs are ignored.
  - `mispredict` is held at 0.
- Lookup in `RUN` (combinational from stored state): hit = `valid & tag==if_pc tag`.
  - `pred_taken = hit & ctr[1]`.
  - `pred_target = pred_taken ? target : if_pc+4`.
- Training in `RUN` occurs when `ex_valid & ex_is_branch`:
  - `ctr` saturating +1 if `ex_taken` (max 3), −1 otherwise (min 0).
  - If `ex_taken`, write `valid=1`, `tag`, and `target=ex_target`.
  - Not-taken never clears `valid`.
- Mispredict condition (same qualifier as training): `ex_taken != ex_pred_taken`, or `ex_taken & ex_pred_taken & ex_target != ex_pred_target`.
- `redirect_pc = ex_taken ? ex_target : ex_pc+4`. All PC arithmetic is modulo 2^32; `0xFFFF_FFFC+4 = 0`.
- Non-branch or `!ex_valid` cycles never train and never mispredict.

## Timing
- Reset values: `bp_ready=0`, `mispredict=0`, `redirect_pc=0`, stats=0, state=`INIT`, sweep index=0.
- `bp_ready` rises exactly ENTRIES cycles after the first edge with `rst_n=1`.
- Lookup is zero-latency. Training commits on the edge that samples it; a lookup in the following cycle sees the new value.
- Same-cycle lookup and training of the same index: the lookup returns pre-update state; there is no bypass.
- `mispredict` and `redirect_pc` are registered and appear one cycle after the resolving `ex_valid` cycle. `mispredict` lasts one cycle per event, and back-to-back events give back-to-back pulses.
- `rst_n` low mid-sweep or mid-`RUN` restarts `INIT` from index 0 and clears `mispredict` the next edge.

## Configuration
- `BRANCH_PRED_STATS_EN` defined:
  - `stat_branches` increments on each `RUN` training cycle.
  - `stat_mispredicts` increments on each mispredict event.
  - Both are 32-bit, wrap at 2^32, and are cleared by reset.
- `BRANCH_PRED_STATS_EN` undefined: both ports are tied to 0 and the counters are not built.

## Test plan
- Reset release with ENTRIES=64 → `bp_ready=0` for 64 cycles, 1 on cycle 64; every lookup meanwhile gives `pred_taken=0`, `pred_target=if_pc+4`.
- Train pc=0x100 taken, target 0x200, `ex_pred_taken=0` → next cycle `mispredict=1`, `redirect_pc=0x200`. Next lookup of 0x100 → ctr=2: `pred_taken=1`, `pred_target=0x200`.
- Train pc=0x100 not-taken 3× from ctr=3 → ctr 2,1,0 (floor). Lookup → `pred_taken=0`, `pred_target=0x104`. A predicted-taken instance gives `redirect_pc=0x104`.
- Aliasing: train 0x100 taken, then look up 0x100+4·ENTRIES → tag miss, `pred_taken=0`.
- Predicted taken to 0x300, actual target 0x400 → `mispredict=1`, `redirect_pc=0x400`. A correct prediction, or `ex_is_branch=0`, gives `mispredict=0`.
- With the macro defined: 10 branches, 3 mispredicts → `stat_branches=10`, `stat_mispredicts=3`. `rst_n=0` mid-run → both counters 0, sweep restarts.
